// File: rtl/rts_pkg.sv
// Shared definitions for the random-test-socket BIST session: state encoding,
// default widths/polynomials and the session shape shared with the controller.
package rts_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCheck,
        StReport
    } rts_state_e;

    localparam int unsigned DefOutSize     = 8;
    localparam int unsigned DefSigWidth    = 16;
    localparam logic [15:0] DefPoly        = 16'h002D;
    localparam int unsigned DefShiftSize   = 1;
    localparam int unsigned DefNumOfRounds = 50;
    localparam int unsigned CountWidth     = 16;

    function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
        return (v == {CountWidth{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rts_lfsr_compactor.sv
// Galois-style LFSR signature register: shifts left, folds the MSB back through
// Poly and XORs in a parallel data word on every enabled cycle.
module rts_lfsr_compactor #(
    parameter int unsigned       Width = 16,
    parameter logic [Width-1:0]  Poly  = '0
) (
    input  logic             clk,
    input  logic             rstIn_n,
    input  logic             clr,
    input  logic             en,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] sig
);

    logic [Width-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[Width-2:0], 1'b0} ^ (sig_q[Width-1] ? Poly : '0) ^ din;
        end
    end

    always_ff @(posedge clk or negedge rstIn_n) begin
        if (!rstIn_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/rts_response_analyzer.sv
// BIST response analyzer: compacts scan-out (SISA) and primary outputs (MISR),
// polices the strobe protocol and reports a sticky pass/fail verdict on done.
module rts_response_analyzer
    import rts_pkg::*;
#(
    parameter int unsigned         OutSize     = DefOutSize,
    parameter int unsigned         SigWidth    = DefSigWidth,
    parameter logic [SigWidth-1:0] MisrPoly    = SigWidth'(DefPoly),
    parameter logic [SigWidth-1:0] SisaPoly    = SigWidth'(DefPoly),
    parameter logic [SigWidth-1:0] GoldenMisr  = '0,
    parameter logic [SigWidth-1:0] GoldenSisa  = '0,
    parameter int unsigned         ShiftSize   = DefShiftSize,
    parameter int unsigned         numOfRounds = DefNumOfRounds
) (
    input  logic                  clk,
    input  logic                  rstIn_n,
    input  logic                  rstOut,
    input  logic                  SISA_En,
    input  logic                  MISR_En,
    input  logic                  done,
    input  logic                  scanOut,
    input  logic [OutSize-1:0]    POs,
    output logic [SigWidth-1:0]   misrSig,
    output logic [SigWidth-1:0]   sisaSig,
    output logic [CountWidth-1:0] roundCount,
    output logic                  protoErr,
    output logic                  resultValid,
    output logic                  pass,
    output logic                  fail
);

    localparam logic [CountWidth-1:0] ShiftTarget = CountWidth'(ShiftSize);
    localparam logic [CountWidth-1:0] RoundTarget = CountWidth'(numOfRounds);

    rts_state_e            state_q, state_d;
    logic [CountWidth-1:0] shift_cnt_q, shift_cnt_d;
    logic [CountWidth-1:0] round_q, round_d;
    logic                  proto_err_q, proto_err_d;
    logic                  pend_q, pend_d;
    logic                  pend_pass_q, pend_pass_d;
    logic                  valid_q, valid_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  misr_en, sisa_en;

    rts_lfsr_compactor #(
        .Width (SigWidth),
        .Poly  (MisrPoly)
    ) u_misr (
        .clk     (clk),
        .rstIn_n (rstIn_n),
        .clr     (rstOut),
        .en      (misr_en),
        .din     (SigWidth'(POs)),
        .sig     (misrSig)
    );

    rts_lfsr_compactor #(
        .Width (SigWidth),
        .Poly  (SisaPoly)
    ) u_sisa (
        .clk     (clk),
        .rstIn_n (rstIn_n),
        .clr     (rstOut),
        .en      (sisa_en),
        .din     (SigWidth'(scanOut)),
        .sig     (sisaSig)
    );

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        round_d     = round_q;
        proto_err_d = proto_err_q;
        pend_d      = pend_q;
        pend_pass_d = pend_pass_q;
        valid_d     = valid_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        misr_en     = 1'b0;
        sisa_en     = 1'b0;

        if (rstOut) begin
            state_d     = StRun;
            shift_cnt_d = '0;
            round_d     = '0;
            proto_err_d = 1'b0;
            pend_d      = 1'b0;
            pend_pass_d = 1'b0;
            valid_d     = 1'b0;
            pass_d      = 1'b0;
            fail_d      = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    sisa_en = SISA_En;
                    misr_en = MISR_En;
                    if (SISA_En) begin
                        shift_cnt_d = sat_inc(shift_cnt_q);
                    end
                    // Closing a round: the count seen here is the pre-increment one,
                    // and an overlapping shift strobe is itself a violation.
                    if (MISR_En) begin
                        round_d     = sat_inc(round_q);
                        shift_cnt_d = '0;
                        if (SISA_En || (shift_cnt_q != ShiftTarget)) begin
                            proto_err_d = 1'b1;
                        end
                    end
                    if (done) begin
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    pend_d      = 1'b1;
                    pend_pass_d = (misrSig == GoldenMisr) && (sisaSig == GoldenSisa) &&
                                  (round_q == RoundTarget) && !proto_err_q;
                    state_d     = StReport;
                end
                StReport: begin
                    // Verdict computed in CHECK is published one cycle later.
                    if (pend_q) begin
                        pend_d  = 1'b0;
                        valid_d = 1'b1;
                        pass_d  = pend_pass_q;
                        fail_d  = !pend_pass_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstIn_n) begin
        if (!rstIn_n) begin
            state_q     <= StIdle;
            shift_cnt_q <= '0;
            round_q     <= '0;
            proto_err_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_pass_q <= 1'b0;
            valid_q     <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            round_q     <= round_d;
            proto_err_q <= proto_err_d;
            pend_q      <= pend_d;
            pend_pass_q <= pend_pass_d;
            valid_q     <= valid_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign roundCount  = round_q;
    assign protoErr    = proto_err_q;
    assign resultValid = valid_q;
    assign pass        = pass_q;
    assign fail        = fail_q;

endmodule

// File: tb/tb_rts_response_analyzer.sv
// Directed bench: default, small (4-bit) and ShiftSize=3 analyzers share one
// stimulus stream; each scenario task checks the instance it targets.
module tb_rts_response_analyzer;

    logic       clk = 1'b0;
    logic       rstIn_n = 1'b0;
    logic       rstOut = 1'b0;
    logic       SISA_En = 1'b0;
    logic       MISR_En = 1'b0;
    logic       done = 1'b0;
    logic       scanOut = 1'b0;
    logic [7:0] POs = 8'h00;

    logic [15:0] d_misr, d_sisa, d_round;
    logic        d_perr, d_valid, d_pass, d_fail;
    logic [3:0]  s_misr, s_sisa;
    logic [15:0] s_round;
    logic        s_perr, s_valid, s_pass, s_fail;
    logic [15:0] p_misr, p_sisa, p_round;
    logic        p_perr, p_valid, p_pass, p_fail;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rts_response_analyzer u_dut (
        .clk(clk), .rstIn_n(rstIn_n), .rstOut(rstOut), .SISA_En(SISA_En), .MISR_En(MISR_En),
        .done(done), .scanOut(scanOut), .POs(POs), .misrSig(d_misr), .sisaSig(d_sisa),
        .roundCount(d_round), .protoErr(d_perr), .resultValid(d_valid), .pass(d_pass),
        .fail(d_fail)
    );

    rts_response_analyzer #(
        .OutSize(4), .SigWidth(4), .MisrPoly(4'h3), .SisaPoly(4'h3),
        .GoldenMisr(4'h0), .GoldenSisa(4'h0)
    ) u_small (
        .clk(clk), .rstIn_n(rstIn_n), .rstOut(rstOut), .SISA_En(SISA_En), .MISR_En(MISR_En),
        .done(done), .scanOut(scanOut), .POs(POs[3:0]), .misrSig(s_misr), .sisaSig(s_sisa),
        .roundCount(s_round), .protoErr(s_perr), .resultValid(s_valid), .pass(s_pass),
        .fail(s_fail)
    );

    rts_response_analyzer #(
        .ShiftSize(3)
    ) u_proto (
        .clk(clk), .rstIn_n(rstIn_n), .rstOut(rstOut), .SISA_En(SISA_En), .MISR_En(MISR_En),
        .done(done), .scanOut(scanOut), .POs(POs), .misrSig(p_misr), .sisaSig(p_sisa),
        .roundCount(p_round), .protoErr(p_perr), .resultValid(p_valid), .pass(p_pass),
        .fail(p_fail)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst_out();
        rstOut = 1'b1;
        tick();
        rstOut = 1'b0;
    endtask

    task automatic do_round(input int shifts);
        for (int i = 0; i < shifts; i++) begin
            SISA_En = 1'b1;
            tick();
        end
        SISA_En = 1'b0;
        MISR_En = 1'b1;
        tick();
        MISR_En = 1'b0;
    endtask

    // done at edge N, CHECK at N+1, verdict visible after N+2
    task automatic finish_session(input string tag, output logic v1, output logic v2);
        done = 1'b1;
        tick();
        v1 = d_valid | p_valid;
        tick();
        v2 = d_valid | p_valid;
        tick();
        done = 1'b0;
        n_checks++;
        if ({v1, v2} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_latency: resultValid early got %b expected 00", tag, {v1, v2});
        end
    endtask

    task automatic test_reset();
        logic [15:0] all_out;
        tick();
        n_checks++;
        if ({d_misr, d_sisa, d_round} !== 48'h0 || {d_perr, d_valid, d_pass, d_fail} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h %h %h %b expected zeros", d_misr, d_sisa, d_round,
                     {d_perr, d_valid, d_pass, d_fail});
        end
        rstIn_n = 1'b1;
        tick();
        pulse_rst_out();
        scanOut = 1'b1;
        POs = 8'hA5;
        do_round(1);
        scanOut = 1'b0;
        n_checks++;
        if (d_misr !== 16'h00A5 || d_sisa !== 16'h0001 || d_round !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_prep: got misr=%h sisa=%h round=%0d expected 00a5 0001 1",
                     d_misr, d_sisa, d_round);
        end
        #2 rstIn_n = 1'b0;
        #1;
        all_out = d_misr | d_sisa | d_round;
        n_checks++;
        if (all_out !== 16'h0 || {d_perr, d_valid, d_pass, d_fail} !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: got or=%h flags=%b expected 0", all_out,
                     {d_perr, d_valid, d_pass, d_fail});
        end
        tick();
        rstIn_n = 1'b1;
        do_round(1);
        done = 1'b1;
        tick();
        tick();
        tick();
        done = 1'b0;
        n_checks++;
        if (d_misr !== 16'h0 || d_round !== 16'h0 || d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: got misr=%h round=%0d valid=%b expected 0 0 0",
                     d_misr, d_round, d_valid);
        end
        POs = 8'h00;
    endtask

    task automatic test_small_arith();
        logic [3:0] exp_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC};
        pulse_rst_out();
        for (int i = 0; i < 7; i++) begin
            POs = (i == 0) ? 8'h01 : 8'h00;
            MISR_En = 1'b1;
            tick();
            MISR_En = 1'b0;
            POs = 8'h00;
            n_checks++;
            if (s_misr !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL small_misr_step%0d: got %h expected %h", i, s_misr, exp_tab[i]);
            end
        end
    endtask

    task automatic test_full_session();
        logic v1, v2;
        pulse_rst_out();
        for (int r = 0; r < 50; r++) do_round(1);
        n_checks++;
        if (d_round !== 16'd50 || d_misr !== 16'h0 || d_sisa !== 16'h0 || d_perr !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pre_done: got round=%0d misr=%h sisa=%h perr=%b expected 50 0 0 0",
                     d_round, d_misr, d_sisa, d_perr);
        end
        finish_session("full", v1, v2);
        n_checks++;
        if ({d_valid, d_pass, d_fail} !== 3'b110) begin
            n_fail++;
            $display("FAIL full_verdict: got valid/pass/fail=%b expected 110",
                     {d_valid, d_pass, d_fail});
        end
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        n_checks++;
        if ({d_valid, d_pass, d_fail} !== 3'b110) begin
            n_fail++;
            $display("FAIL full_hold: got valid/pass/fail=%b expected 110",
                     {d_valid, d_pass, d_fail});
        end
    endtask

    task automatic test_round_mismatch();
        logic v1, v2;
        pulse_rst_out();
        for (int r = 0; r < 49; r++) do_round(1);
        finish_session("rounds49", v1, v2);
        n_checks++;
        if ({d_valid, d_pass, d_fail, d_perr} !== 4'b1010 || d_round !== 16'd49) begin
            n_fail++;
            $display("FAIL rounds49_verdict: got v/p/f/perr=%b round=%0d expected 1010 49",
                     {d_valid, d_pass, d_fail, d_perr}, d_round);
        end
    endtask

    task automatic test_protocol();
        logic v1, v2;
        pulse_rst_out();
        do_round(2);
        n_checks++;
        if (p_perr !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_short_round: got protoErr=%b expected 1", p_perr);
        end
        finish_session("proto_short", v1, v2);
        n_checks++;
        if ({p_valid, p_pass, p_fail} !== 3'b101) begin
            n_fail++;
            $display("FAIL proto_short_verdict: got v/p/f=%b expected 101",
                     {p_valid, p_pass, p_fail});
        end
        pulse_rst_out();
        n_checks++;
        if ({p_perr, p_valid, p_pass, p_fail} !== 4'b0000) begin
            n_fail++;
            $display("FAIL proto_clear: got perr/v/p/f=%b expected 0000",
                     {p_perr, p_valid, p_pass, p_fail});
        end
        SISA_En = 1'b1;
        MISR_En = 1'b1;
        tick();
        SISA_En = 1'b0;
        MISR_En = 1'b0;
        n_checks++;
        if (p_perr !== 1'b1 || d_perr !== 1'b1 || p_round !== 16'd1) begin
            n_fail++;
            $display("FAIL proto_overlap: got perr=%b/%b round=%0d expected 1/1 1",
                     p_perr, d_perr, p_round);
        end
        finish_session("proto_overlap", v1, v2);
        n_checks++;
        if ({p_valid, p_pass, p_fail} !== 3'b101 || {d_pass, d_fail} !== 2'b01) begin
            n_fail++;
            $display("FAIL proto_overlap_verdict: got v/p/f=%b dflt p/f=%b expected 101 01",
                     {p_valid, p_pass, p_fail}, {d_pass, d_fail});
        end
    endtask

    task automatic test_restart();
        logic v1, v2;
        pulse_rst_out();
        n_checks++;
        if ({d_valid, d_pass, d_fail, d_perr} !== 4'b0000 || d_round !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_clear: got v/p/f/perr=%b round=%0d expected 0000 0",
                     {d_valid, d_pass, d_fail, d_perr}, d_round);
        end
        POs = 8'h3C;
        scanOut = 1'b1;
        do_round(1);
        POs = 8'h00;
        scanOut = 1'b0;
        n_checks++;
        if (d_misr !== 16'h003C || d_sisa !== 16'h0001) begin
            n_fail++;
            $display("FAIL restart_partial: got misr=%h sisa=%h expected 003c 0001",
                     d_misr, d_sisa);
        end
        pulse_rst_out();
        for (int r = 0; r < 50; r++) do_round(1);
        finish_session("restart", v1, v2);
        n_checks++;
        if ({d_valid, d_pass, d_fail, d_perr} !== 4'b1100 || d_round !== 16'd50) begin
            n_fail++;
            $display("FAIL restart_verdict: got v/p/f/perr=%b round=%0d expected 1100 50",
                     {d_valid, d_pass, d_fail, d_perr}, d_round);
        end
    endtask

    initial begin
        test_reset();
        test_small_arith();
        test_full_session();
        test_round_mismatch();
        test_protocol();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
